// File: rtl/osc_startup_seq.sv
// Oscillator/PLL startup sequencer: holds the fabric in reset, waits for a stable CCC lock,
// then releases SYS_RST and runs a timebase strobe while lock is maintained.
module osc_startup_seq #(
    parameter int unsigned HOLD_CYCLES   = 1000,
    parameter int unsigned SETTLE_CYCLES = 256,
    parameter int unsigned TICK_DIV      = 50000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       LOCK,
    input  logic       SW_RST,
    output logic       SYS_RST,
    output logic       READY,
    output logic       TICK,
    output logic [7:0] LOCK_LOSS_CNT,
    output logic [2:0] STATE
);

    typedef enum logic [2:0] {
        StHold     = 3'd0,
        StWaitLock = 3'd1,
        StSettle   = 3'd2,
        StRun      = 3'd3
    } state_e;

    localparam logic [15:0] HoldLast   = 16'(HOLD_CYCLES - 1);
    localparam logic [15:0] SettleLast = 16'(SETTLE_CYCLES - 1);
    localparam logic [19:0] DivLast    = 20'(TICK_DIV - 1);

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [19:0] div_q, div_d;
    logic [7:0]  loss_cnt_q, loss_cnt_d;
    logic        lock_meta_q, lock_s_q;
    logic        sys_rst_q, sys_rst_d;
    logic        ready_q, ready_d;
    logic        tick_q, tick_d;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        loss_cnt_d = loss_cnt_q;
        div_d      = '0;
        tick_d     = 1'b0;

        if (SW_RST) begin
            state_d = StHold;
            cnt_d   = '0;
        end else begin
            case (state_q)
                StHold: begin
                    if (cnt_q == HoldLast) begin
                        state_d = StWaitLock;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
                StWaitLock: begin
                    cnt_d = '0;
                    if (lock_s_q) begin
                        state_d = StSettle;
                    end
                end
                StSettle: begin
                    if (!lock_s_q) begin
                        state_d = StWaitLock;
                        cnt_d   = '0;
                    end else if (cnt_q == SettleLast) begin
                        state_d = StRun;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
                StRun: begin
                    cnt_d = '0;
                    if (!lock_s_q) begin
                        state_d = StWaitLock;
                        if (loss_cnt_q != 8'hFF) begin
                            loss_cnt_d = loss_cnt_q + 8'd1;
                        end
                    end
                end
                default: begin
                    state_d = StHold;
                    cnt_d   = '0;
                end
            endcase
        end

        // Divider only advances while staying in RUN, so no strobe can leak on a RUN exit edge.
        if (state_q == StRun && state_d == StRun) begin
            if (div_q == DivLast) begin
                div_d  = '0;
                tick_d = 1'b1;
            end else begin
                div_d = div_q + 20'd1;
            end
        end

        sys_rst_d = (state_d != StRun);
        ready_d   = (state_d == StRun);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= StHold;
            cnt_q       <= '0;
            div_q       <= '0;
            loss_cnt_q  <= '0;
            lock_meta_q <= 1'b0;
            lock_s_q    <= 1'b0;
            sys_rst_q   <= 1'b1;
            ready_q     <= 1'b0;
            tick_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            div_q       <= div_d;
            loss_cnt_q  <= loss_cnt_d;
            lock_meta_q <= LOCK;
            lock_s_q    <= lock_meta_q;
            sys_rst_q   <= sys_rst_d;
            ready_q     <= ready_d;
            tick_q      <= tick_d;
        end
    end

    assign SYS_RST       = sys_rst_q;
    assign READY         = ready_q;
    assign TICK          = tick_q;
    assign LOCK_LOSS_CNT = loss_cnt_q;
    assign STATE         = state_q;

endmodule

// File: tb/tb_osc_startup_seq.sv
// Directed bench for osc_startup_seq with HOLD=8, SETTLE=4, TICK_DIV=5; edge n is the n-th
// rising CLK edge after RST release, sampled 1 time unit after that edge.
module tb_osc_startup_seq;

    logic       clk;
    logic       rst;
    logic       lock;
    logic       sw_rst;
    logic       sys_rst;
    logic       ready;
    logic       tick;
    logic [7:0] llc;
    logic [2:0] state;

    int n_cmp = 0;
    int n_err = 0;

    osc_startup_seq #(
        .HOLD_CYCLES  (8),
        .SETTLE_CYCLES(4),
        .TICK_DIV     (5)
    ) dut (
        .CLK          (clk),
        .RST          (rst),
        .LOCK         (lock),
        .SW_RST       (sw_rst),
        .SYS_RST      (sys_rst),
        .READY        (ready),
        .TICK         (tick),
        .LOCK_LOSS_CNT(llc),
        .STATE        (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clk_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_edge(input int e, input logic [2:0] st, input logic tk,
                            input logic [7:0] cnt);
        check($sformatf("e%0d state", e), 32'(state), 32'(st));
        check($sformatf("e%0d sys_rst", e), 32'(sys_rst), 32'(st != 3'd3));
        check($sformatf("e%0d ready", e), 32'(ready), 32'(st == 3'd3));
        check($sformatf("e%0d tick", e), 32'(tick), 32'(tk));
        check($sformatf("e%0d llc", e), 32'(llc), 32'(cnt));
    endtask

    // Assert RST with the given LOCK level, check reset values, release just after a falling edge.
    task automatic do_reset(input logic lock_v);
        rst    = 1'b1;
        lock   = lock_v;
        sw_rst = 1'b0;
        clk_edge();
        clk_edge();
        check("rst state", 32'(state), 32'd0);
        check("rst sys_rst", 32'(sys_rst), 32'd1);
        check("rst ready", 32'(ready), 32'd0);
        check("rst tick", 32'(tick), 32'd0);
        check("rst llc", 32'(llc), 32'd0);
        @(negedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic wait_state(input logic [2:0] tgt, input int budget, input string tag);
        int n = 0;
        while (state !== tgt && n < budget) begin
            clk_edge();
            n++;
        end
        check(tag, 32'(state), 32'(tgt));
    endtask

    initial begin
        logic [2:0] st;
        logic       tk;
        logic [7:0] cnt;

        rst    = 1'b1;
        lock   = 1'b0;
        sw_rst = 1'b0;

        // Startup with LOCK high throughout.
        do_reset(1'b1);
        for (int e = 1; e <= 30; e++) begin
            clk_edge();
            st = (e < 8) ? 3'd0 : (e == 8) ? 3'd1 : (e < 13) ? 3'd2 : 3'd3;
            tk = (e >= 18) && ((e - 18) % 5 == 0);
            chk_edge(e, st, tk, 8'd0);
        end

        // Late lock: LOCK rises just before edge 20.
        do_reset(1'b0);
        for (int e = 1; e <= 30; e++) begin
            clk_edge();
            st = (e < 8) ? 3'd0 : (e < 22) ? 3'd1 : (e < 26) ? 3'd2 : 3'd3;
            chk_edge(e, st, 1'b0, 8'd0);
            if (e == 19) lock = 1'b1;
        end

        // Settle glitch, lock loss in RUN, relock, then SW_RST coincident with a lock loss.
        do_reset(1'b1);
        for (int e = 1; e <= 56; e++) begin
            clk_edge();
            if      (e < 8)   st = 3'd0;
            else if (e == 8)  st = 3'd1;
            else if (e < 13)  st = 3'd2;
            else if (e == 13) st = 3'd1;
            else if (e < 18)  st = 3'd2;
            else if (e < 28)  st = 3'd3;
            else if (e < 31)  st = 3'd1;
            else if (e < 35)  st = 3'd2;
            else if (e < 39)  st = 3'd3;
            else if (e < 47)  st = 3'd0;
            else if (e == 47) st = 3'd1;
            else if (e < 52)  st = 3'd2;
            else              st = 3'd3;
            tk  = (e == 23);
            cnt = (e >= 28) ? 8'd1 : 8'd0;
            chk_edge(e, st, tk, cnt);
            case (e)
                10: lock = 1'b0;
                11: lock = 1'b1;
                25: lock = 1'b0;
                28: lock = 1'b1;
                36: lock = 1'b0;
                38: sw_rst = 1'b1;
                39: begin
                    sw_rst = 1'b0;
                    lock   = 1'b1;
                end
                default: ;
            endcase
        end

        // Asynchronous RST between edges while in RUN.
        #3;
        rst = 1'b1;
        #1;
        check("async sys_rst", 32'(sys_rst), 32'd1);
        check("async ready", 32'(ready), 32'd0);
        check("async state", 32'(state), 32'd0);
        check("async llc", 32'(llc), 32'd0);

        // Saturation of the lock-loss counter.
        do_reset(1'b1);
        wait_state(3'd3, 30, "sat initial run");
        for (int i = 0; i < 300; i++) begin
            lock = 1'b0;
            wait_state(3'd1, 10, "sat loss");
            lock = 1'b1;
            wait_state(3'd3, 20, "sat relock");
            if (i == 0)   check("sat llc after 1", 32'(llc), 32'd1);
            if (i == 253) check("sat llc after 254", 32'(llc), 32'd254);
        end
        check("sat llc after 300", 32'(llc), 32'd255);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
